// File: rtl/tag_record_packer.sv
// tag_record_packer: captures masked TDC hits into a record FIFO and streams
// each record as SYNC_BYTE followed by a little-endian payload, one byte per
// omux_sel_i handshake. Drops on a full FIFO are counted and flagged into the
// next stored record.
module tag_record_packer #(
  parameter int          CHANNEL_COUNT = 2,
  parameter int          TS_WIDTH      = 32,
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                enable_i,
  input  logic [CHANNEL_COUNT-1:0]            chan_mask_i,
  input  logic [CHANNEL_COUNT-1:0]            detect_i,
  input  logic [CHANNEL_COUNT-1:0]            polarity_i,
  input  logic [CHANNEL_COUNT*TS_WIDTH-1:0]   ts_i,
  output logic [7:0]                          omux_data_o,
  output logic                                omux_req_o,
  input  logic                                omux_sel_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level_o,
  output logic [15:0]                         overflow_count_o,
  input  logic                                overflow_clr_i
);

  localparam int P  = 1 + 2*CHANNEL_COUNT + CHANNEL_COUNT*TS_WIDTH;
  localparam int PB = (P + 7) / 8;
  localparam int PW = PB * 8;
  localparam int RB = PB + 1;            // bytes per record incl. sync
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = $clog2(RB+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  state_t              r_state, w_next;
  logic [PW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr, r_rd;
  logic [LW-1:0]       r_count;
  logic                r_lost;
  logic [15:0]         r_ovf;
  logic [PW-1:0]       r_pay, r_shift;
  logic [CW-1:0]       r_bcnt;
  logic [7:0]          r_data;
  logic                r_req;

  logic [CHANNEL_COUNT-1:0] w_m;
  logic                     w_evt, w_full, w_push, w_drop, w_pop;
  logic [PW-1:0]            w_pay;

  assign w_m    = detect_i & chan_mask_i;
  assign w_evt  = enable_i & (|w_m);
  // Full blocks a push even if a pop happens the same cycle.
  assign w_full = (r_count == LW'(FIFO_DEPTH));
  assign w_push = w_evt & ~w_full;
  assign w_drop = w_evt & w_full;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

  // Assemble the payload: masked timestamps, hit mask, masked polarity, lost bit.
  always_comb begin
    w_pay = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++)
      if (w_m[i]) w_pay[i*TS_WIDTH +: TS_WIDTH] = ts_i[i*TS_WIDTH +: TS_WIDTH];
    w_pay[CHANNEL_COUNT*TS_WIDTH +: CHANNEL_COUNT]               = w_m;
    w_pay[CHANNEL_COUNT*TS_WIDTH+CHANNEL_COUNT +: CHANNEL_COUNT] = polarity_i & w_m;
    w_pay[P-1] = r_lost;
  end

  // Record storage; contents are don't-care after reset, pointers are not.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= w_pay;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Lost flag rides on the next stored record; drop counter saturates, clear wins.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lost <= 1'b0;
      r_ovf  <= '0;
    end else begin
      if (w_drop)      r_lost <= 1'b1;
      else if (w_push) r_lost <= 1'b0;
      if (overflow_clr_i)                r_ovf <= '0;
      else if (w_drop && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
    end
  end

  // Sender state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Sender next-state: pop, latch, then one byte per handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_LOAD;
      S_LOAD:  w_next = S_SEND;
      S_SEND:  if (omux_sel_i && r_bcnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sender datapath: registered byte/req, payload shifted out LSB byte first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pay   <= '0;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_data  <= '0;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) r_pay <= r_mem[r_rd];
        S_LOAD: begin
          r_shift <= r_pay;
          r_data  <= SYNC_BYTE;
          r_req   <= 1'b1;
          r_bcnt  <= CW'(RB-1);
        end
        S_SEND: if (omux_sel_i) begin
          if (r_bcnt == '0) begin
            r_req  <= 1'b0;
            r_data <= '0;
          end else begin
            r_data  <= r_shift[7:0];
            r_shift <= r_shift >> 8;
            r_bcnt  <= r_bcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign omux_data_o      = r_data;
  assign omux_req_o       = r_req;
  assign fifo_level_o     = r_count;
  assign overflow_count_o = r_ovf;

endmodule

// File: tb/tb_tag_record_packer.sv
// Directed bench for tag_record_packer at default parameters.
module tb_tag_record_packer;

  logic        clk = 1'b0;
  logic        reset_i, enable_i, omux_sel_i, overflow_clr_i;
  logic [1:0]  chan_mask_i, detect_i, polarity_i;
  logic [63:0] ts_i;
  logic [7:0]  omux_data_o;
  logic        omux_req_o;
  logic [4:0]  fifo_level_o;
  logic [15:0] overflow_count_o;

  int checks = 0;
  int errors = 0;

  tag_record_packer dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .chan_mask_i(chan_mask_i), .detect_i(detect_i), .polarity_i(polarity_i),
    .ts_i(ts_i), .omux_data_o(omux_data_o), .omux_req_o(omux_req_o),
    .omux_sel_i(omux_sel_i), .fifo_level_o(fifo_level_o),
    .overflow_count_o(overflow_count_o), .overflow_clr_i(overflow_clr_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one event for a single cycle.
  task automatic event1(input logic [1:0] det, input logic [1:0] pol, input logic [63:0] ts);
    detect_i = det; polarity_i = pol; ts_i = ts;
    step();
    detect_i = 2'b00;
  endtask

  // Consume one full record with sel held high; e holds bytes, first byte in MSBs.
  task automatic collect(input string tag, input logic [79:0] e);
    int n = 0;
    omux_sel_i = 1'b1;
    while (!omux_req_o && n < 40) begin step(); n++; end
    chk({tag, "_req"}, 32'(omux_req_o), 32'd1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_b%0d", tag, k), 32'(omux_data_o), 32'(e[79-8*k -: 8]));
      step();
    end
    chk({tag, "_end"}, 32'(omux_req_o), 32'd0);
  endtask

  initial begin
    reset_i = 1'b1; enable_i = 1'b1; omux_sel_i = 1'b0; overflow_clr_i = 1'b0;
    chan_mask_i = 2'b11; detect_i = 2'b00; polarity_i = 2'b00; ts_i = '0;
    step(); step();
    reset_i = 1'b0;
    chk("rst_req",   32'(omux_req_o),       32'd0);
    chk("rst_data",  32'(omux_data_o),      32'd0);
    chk("rst_level", 32'(fifo_level_o),     32'd0);
    chk("rst_ovf",   32'(overflow_count_o), 32'd0);

    // Single event: latency N+3 then the 10-byte record.
    omux_sel_i = 1'b1;
    chan_mask_i = 2'b01;
    event1(2'b11, 2'b11, {32'hAABBCCDD, 32'h11223344});
    chk("lat_n1", 32'(omux_req_o), 32'd0);
    step();
    chk("lat_n2", 32'(omux_req_o), 32'd0);
    step();
    chk("lat_n3", 32'(omux_req_o), 32'd1);
    collect("single", {8'hA5, 32'h44332211, 32'h0, 8'h05});

    // Masking: masked-off hit produces nothing; partial mask zeroes ch0.
    chan_mask_i = 2'b10;
    event1(2'b01, 2'b01, {32'hAABBCCDD, 32'h11223344});
    repeat (4) step();
    chk("mask_level", 32'(fifo_level_o), 32'd0);
    chk("mask_req",   32'(omux_req_o),   32'd0);
    event1(2'b11, 2'b11, {32'hAABBCCDD, 32'h11223344});
    collect("mask", {8'hA5, 32'h0, 32'hDDCCBBAA, 8'h0A});
    chan_mask_i = 2'b11;

    // Backpressure: sync byte held for 20 cycles, then full record.
    omux_sel_i = 1'b0;
    event1(2'b01, 2'b00, {32'hFFFFFFFF, 32'h01020304});
    repeat (3) step();
    for (int i = 0; i < 20; i++) begin
      chk("bp_req",  32'(omux_req_o),  32'd1);
      chk("bp_data", 32'(omux_data_o), 32'hA5);
      step();
    end
    chk("bp_level", 32'(fifo_level_o), 32'd0);
    collect("bp", {8'hA5, 32'h04030201, 32'h0, 8'h01});

    // Overflow: 18 back-to-back events, sender stalled.
    omux_sel_i = 1'b0;
    for (int i = 0; i < 18; i++) begin
      detect_i = 2'b01; polarity_i = 2'b00; ts_i = {32'hDEADBEEF, 32'(i)};
      step();
    end
    detect_i = 2'b00;
    step(); step();
    chk("ovf_level", 32'(fifo_level_o),     32'd16);
    chk("ovf_count", 32'(overflow_count_o), 32'd1);
    for (int r = 0; r < 17; r++)
      collect($sformatf("drain%0d", r), {8'hA5, 8'(r), 24'h0, 32'h0, 8'h01});
    event1(2'b01, 2'b00, {32'h0, 32'h55667788});
    collect("lost1", {8'hA5, 32'h88776655, 32'h0, 8'h11});
    event1(2'b01, 2'b00, {32'h0, 32'h55667788});
    collect("lost0", {8'hA5, 32'h88776655, 32'h0, 8'h01});

    // Counter saturation, then clear colliding with a drop.
    omux_sel_i = 1'b0;
    detect_i = 2'b01; polarity_i = 2'b00; ts_i = '0;
    repeat (65600) step();
    chk("sat", 32'(overflow_count_o), 32'hFFFF);
    overflow_clr_i = 1'b1;
    step();
    overflow_clr_i = 1'b0;
    detect_i = 2'b00;
    chk("clr_wins", 32'(overflow_count_o), 32'd0);

    // Reset mid-record after three bytes leave.
    omux_sel_i = 1'b1;
    chk("pre_rst_req", 32'(omux_req_o), 32'd1);
    repeat (3) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("mid_rst_req",   32'(omux_req_o),   32'd0);
    chk("mid_rst_data",  32'(omux_data_o),  32'd0);
    chk("mid_rst_level", 32'(fifo_level_o), 32'd0);
    step();
    event1(2'b11, 2'b10, {32'h12345678, 32'hCAFEBABE});
    collect("post_rst", {8'hA5, 32'hBEBAFECA, 32'h78563412, 8'h0B});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
